// File: rtl/cpu_boot_loader_if.sv
// Bundle between the boot loader and its surroundings: configuration, load stream,
// cpu imem/dmem external ports, run enable, dump stream and status.
interface cpu_boot_loader_if #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int CNT_W       = 32
);
  // Both streams use valid/ready: a beat transfers on a rising clock edge where valid and
  // ready are both high; a source holds valid and data stable until that edge.
  logic                   start;
  logic [IMEM_ADDR_W:0]   imem_len;
  logic [DMEM_ADDR_W:0]   dmem_len;
  logic [CNT_W-1:0]       run_cycles;
  logic [DMEM_ADDR_W-1:0] dump_base;
  logic [DMEM_ADDR_W:0]   dump_len;

  logic                   s_valid;
  logic [63:0]            s_data;
  logic                   s_ready;

  logic [63:0]            addr_ext;
  logic                   wen_ext;
  logic                   ren_ext;
  logic [31:0]            wdata_ext;

  logic [63:0]            addr_ext_2;
  logic                   wen_ext_2;
  logic                   ren_ext_2;
  logic [63:0]            wdata_ext_2;
  logic [63:0]            rdata_ext_2;

  logic                   enable;

  logic                   m_valid;
  logic [63:0]            m_data;
  logic                   m_ready;

  logic                   busy;
  logic                   done;
  logic [2:0]             state_dbg;

  modport master (
    input  start, imem_len, dmem_len, run_cycles, dump_base, dump_len,
    input  s_valid, s_data, rdata_ext_2, m_ready,
    output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    output enable, m_valid, m_data, busy, done, state_dbg
  );

  modport slave (
    output start, imem_len, dmem_len, run_cycles, dump_base, dump_len,
    output s_valid, s_data, rdata_ext_2, m_ready,
    input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    input  enable, m_valid, m_data, busy, done, state_dbg
  );
endinterface

// File: rtl/cpu_boot_loader.sv
// Host-side initiator for the cpu memory ports: loads imem and dmem from a stream,
// runs the cpu for a fixed cycle count, then streams a dmem window back out.
module cpu_boot_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  cpu_boot_loader_if.master  bus
);
  localparam int IDX_W = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;
  localparam logic [IMEM_ADDR_W:0] IMEM_MAX = {1'b1, {IMEM_ADDR_W{1'b0}}};
  localparam logic [DMEM_ADDR_W:0] DMEM_MAX = {1'b1, {DMEM_ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_I   = 3'd1,
    S_LOAD_D   = 3'd2,
    S_RUN      = 3'd3,
    S_DUMP_RD  = 3'd4,
    S_DUMP_OUT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                 state;
  logic [IMEM_ADDR_W:0]   imem_len_q;
  logic [DMEM_ADDR_W:0]   dmem_len_q;
  logic [CNT_W-1:0]       run_q;
  logic [DMEM_ADDR_W-1:0] base_q;
  logic [DMEM_ADDR_W:0]   dump_len_q;
  logic [IDX_W-1:0]       idx;
  logic [CNT_W-1:0]       run_cnt;
  logic [DMEM_ADDR_W:0]   k;
  logic [63:0]            m_data_q;
  logic                   out_first;
  logic                   done_q;

  logic [IMEM_ADDR_W:0]   imem_len_c;
  logic [DMEM_ADDR_W:0]   dmem_len_c;
  logic [DMEM_ADDR_W-1:0] dump_addr;

  assign imem_len_c = (bus.imem_len > IMEM_MAX) ? IMEM_MAX : bus.imem_len;
  assign dmem_len_c = (bus.dmem_len > DMEM_MAX) ? DMEM_MAX : bus.dmem_len;
  assign dump_addr  = base_q + k[DMEM_ADDR_W-1:0];

  // First phase at or after s whose length is non-zero; empty phases cost no cycles.
  function automatic state_t skip_from(input state_t s, input logic il, input logic dl,
                                       input logic rc, input logic dp);
    state_t r;
    r = S_DONE;
    if (dp && s <= S_DUMP_RD) r = S_DUMP_RD;
    if (rc && s <= S_RUN)     r = S_RUN;
    if (dl && s <= S_LOAD_D)  r = S_LOAD_D;
    if (il && s <= S_LOAD_I)  r = S_LOAD_I;
    return r;
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      imem_len_q <= '0;
      dmem_len_q <= '0;
      run_q      <= '0;
      base_q     <= '0;
      dump_len_q <= '0;
      idx        <= '0;
      run_cnt    <= '0;
      k          <= '0;
      m_data_q   <= '0;
      out_first  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            imem_len_q <= imem_len_c;
            dmem_len_q <= dmem_len_c;
            run_q      <= bus.run_cycles;
            base_q     <= bus.dump_base;
            dump_len_q <= bus.dump_len;
            idx        <= '0;
            run_cnt    <= '0;
            k          <= '0;
            state      <= skip_from(S_LOAD_I, |imem_len_c, |dmem_len_c,
                                    |bus.run_cycles, |bus.dump_len);
          end
        end
        S_LOAD_I: begin
          if (bus.s_valid) begin
            if (idx + 1'b1 == IDX_W'(imem_len_q)) begin
              idx   <= '0;
              state <= skip_from(S_LOAD_D, 1'b0, |dmem_len_q, |run_q, |dump_len_q);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_LOAD_D: begin
          if (bus.s_valid) begin
            if (idx + 1'b1 == IDX_W'(dmem_len_q)) begin
              idx   <= '0;
              state <= skip_from(S_RUN, 1'b0, 1'b0, |run_q, |dump_len_q);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (run_cnt == run_q - 1'b1) begin
            run_cnt <= '0;
            state   <= skip_from(S_DUMP_RD, 1'b0, 1'b0, 1'b0, |dump_len_q);
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_DUMP_RD: begin
          out_first <= 1'b1;
          state     <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          // Read data is only on the bus during the first DUMP_OUT cycle; keep it for stalls.
          if (out_first) begin
            m_data_q  <= bus.rdata_ext_2;
            out_first <= 1'b0;
          end
          if (bus.m_ready) begin
            if (k + 1'b1 == dump_len_q) begin
              k     <= '0;
              state <= S_DONE;
            end else begin
              k     <= k + 1'b1;
              state <= S_DUMP_RD;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready     = (state == S_LOAD_I) || (state == S_LOAD_D);
  assign bus.wen_ext     = (state == S_LOAD_I) && bus.s_valid;
  assign bus.addr_ext    = (state == S_LOAD_I) ? 64'({idx[IMEM_ADDR_W-1:0], 2'b00}) : 64'd0;
  assign bus.wdata_ext   = bus.wen_ext ? bus.s_data[31:0] : 32'd0;
  assign bus.ren_ext     = 1'b0;

  assign bus.wen_ext_2   = (state == S_LOAD_D) && bus.s_valid;
  assign bus.ren_ext_2   = (state == S_DUMP_RD);
  assign bus.addr_ext_2  = (state == S_LOAD_D)  ? 64'({idx[DMEM_ADDR_W-1:0], 3'b000}) :
                           (state == S_DUMP_RD) ? 64'({dump_addr, 3'b000}) : 64'd0;
  assign bus.wdata_ext_2 = bus.wen_ext_2 ? bus.s_data : 64'd0;

  assign bus.enable      = (state == S_RUN);
  assign bus.m_valid     = (state == S_DUMP_OUT);
  assign bus.m_data      = (state != S_DUMP_OUT) ? 64'd0 :
                           out_first ? bus.rdata_ext_2 : m_data_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.state_dbg   = state;
endmodule
